// File: rtl/jk_counter_pkg.sv
// Shared types and helpers for the JK-based counter: the {J,K} operation
// encoding and the minimal excitation for a single-bit transition.
package jk_counter_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TOG  = 2'b11
  } jk_op_t;

  // Smallest {J,K} that moves a cell from cur to nxt (don't-cares resolved to 0).
  function automatic jk_op_t jk_excite(input logic cur, input logic nxt);
    jk_op_t op;
    case ({cur, nxt})
      2'b01:   op = SET;
      2'b10:   op = CLR;
      default: op = HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/jk_cell_r.sv
// One JK storage bit, falling-edge clocked, asynchronously cleared by an
// active-low reset.
module jk_cell_r
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      case (jk_op_t'({j_i, k_i}))
        HOLD: q_q <= q_q;
        CLR:  q_q <= 1'b0;
        SET:  q_q <= 1'b1;
        TOG:  q_q <= ~q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter: excitation logic driving WIDTH JK cells,
// plus terminal-count decode and a registered wrap pulse.
module jk_sync_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic [WIDTH-1:0] dc;
  logic [WIDTH-1:0] low_ones;
  logic [WIDTH-1:0] low_zeros;
  logic [WIDTH-1:0] wrap_val;
  logic             at_max;
  logic             at_zero;
  logic             wrap_up;
  logic             wrap_dn;
  logic             wrap_d;
  logic             wrap_q;

  // Out-of-range load values saturate so Q never leaves 0..MODULUS-1.
  assign dc       = ({1'b0, D} >= MOD_EXT) ? MAX_Q : D;
  assign at_max   = (q_q == MAX_Q);
  assign at_zero  = (q_q == '0);
  assign wrap_up  = EN & UP & at_max;
  assign wrap_dn  = EN & ~UP & at_zero;
  assign wrap_val = UP ? '0 : MAX_Q;

  // Ripple-free toggle conditions: bit i toggles when all lower bits are 1 (up) or 0 (down).
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_low
      if (gi == 0) begin : g_lsb
        assign low_ones[gi]  = 1'b1;
        assign low_zeros[gi] = 1'b1;
      end else begin : g_upper
        assign low_ones[gi]  = &q_q[gi-1:0];
        assign low_zeros[gi] = ~|q_q[gi-1:0];
      end
    end
  endgenerate

  always_comb begin
    j_d = '0;
    k_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LOAD) begin
        j_d[i] = dc[i];
        k_d[i] = ~dc[i];
      end else if (EN) begin
        if (wrap_up || wrap_dn) begin
          j_d[i] = wrap_val[i];
          k_d[i] = ~wrap_val[i];
        end else if (UP) begin
          j_d[i] = low_ones[i];
          k_d[i] = low_ones[i];
        end else begin
          j_d[i] = low_zeros[i];
          k_d[i] = low_zeros[i];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell_r u_cell (
        .clk   (CLK),
        .rst_n (nRESET),
        .j_i   (j_d[gi]),
        .k_i   (k_d[gi]),
        .q_o   (q_q[gi])
      );
    end
  endgenerate

  // A load on the same edge suppresses the wrap pulse.
  assign wrap_d = ~LOAD & (wrap_up | wrap_dn);

  always_ff @(negedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign TC   = EN & (UP ? at_max : at_zero);
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed checks of jk_sync_counter: a decade counter (WIDTH=4, MODULUS=10)
// and a 3-bit binary counter (WIDTH=3, MODULUS=8).
module tb_jk_sync_counter;

  logic       clk;
  logic       n_reset;
  logic       en_a, up_a, load_a;
  logic [3:0] d_a, q_a;
  logic       tc_a, wrap_a;
  logic       en_b, up_b, load_b;
  logic [2:0] d_b, q_b;
  logic       tc_b, wrap_b;

  int vectors = 0;
  int errs    = 0;
  int cur;

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .CLK(clk), .nRESET(n_reset), .EN(en_a), .UP(up_a), .LOAD(load_a),
    .D(d_a), .Q(q_a), .TC(tc_a), .WRAP(wrap_a)
  );

  jk_sync_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
    .CLK(clk), .nRESET(n_reset), .EN(en_b), .UP(up_b), .LOAD(load_b),
    .D(d_b), .Q(q_b), .TC(tc_b), .WRAP(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past the next falling edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_reset = 1'b0;
    en_a = 1'b1; up_a = 1'b0; load_a = 1'b0; d_a = 4'd0;
    en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; d_b = 3'd0;
    #1;
    check("rst_q", int'(q_a), 0);
    check("rst_wrap", int'(wrap_a), 0);
    check("rst_tc_down", int'(tc_a), 1);
    #2 n_reset = 1'b1;

    // Count up to 7, then reset between edges.
    up_a = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("pre_up", int'(q_a), k);
    end
    #2 n_reset = 1'b0;
    #1;
    check("midrst_q", int'(q_a), 0);
    check("midrst_wrap", int'(wrap_a), 0);
    check("midrst_tc", int'(tc_a), 0);
    n_reset = 1'b1;

    // Up wrap through 9 -> 0.
    cur = 0;
    for (int k = 0; k < 12; k++) begin
      check("up_tc", int'(tc_a), (cur == 9) ? 1 : 0);
      tick();
      cur = (cur + 1) % 10;
      check("up_q", int'(q_a), cur);
      check("up_wrap", int'(wrap_a), (cur == 0) ? 1 : 0);
    end

    // Direction change at Q=2, then down wrap from 1.
    up_a = 1'b0;
    tick();
    check("dir_q", int'(q_a), 1);
    check("dn_tc1", int'(tc_a), 0);
    tick();
    check("dn_q0", int'(q_a), 0);
    check("dn_w0", int'(wrap_a), 0);
    check("dn_tc0", int'(tc_a), 1);
    tick();
    check("dn_q9", int'(q_a), 9);
    check("dn_w9", int'(wrap_a), 1);
    tick();
    check("dn_q8", int'(q_a), 8);
    check("dn_w8", int'(wrap_a), 0);

    // Load with clamp, then load at the up-terminal count.
    load_a = 1'b1; up_a = 1'b1; d_a = 4'd13;
    tick();
    check("ld_clamp", int'(q_a), 9);
    check("ld_clamp_w", int'(wrap_a), 0);
    d_a = 4'd6;
    #1;
    check("ld_tc_unmasked", int'(tc_a), 1);
    tick();
    check("ld_q6", int'(q_a), 6);
    check("ld_w6", int'(wrap_a), 0);

    // Hold for 5 edges at 3.
    d_a = 4'd3;
    tick();
    check("ld_q3", int'(q_a), 3);
    load_a = 1'b0; en_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_q", int'(q_a), 3);
      check("hold_tc", int'(tc_a), 0);
    end

    // Inputs active only around a rising edge must not act.
    #3;
    en_a = 1'b1; load_a = 1'b1; d_a = 4'd5;
    @(posedge clk);
    #1;
    en_a = 1'b0; load_a = 1'b0; d_a = 4'd0;
    tick();
    check("rise_q", int'(q_a), 3);

    // Single up then down step after hold.
    en_a = 1'b1; up_a = 1'b1;
    tick();
    check("step_up", int'(q_a), 4);
    up_a = 1'b0;
    tick();
    check("step_dn", int'(q_a), 3);
    en_a = 1'b0;

    // Power-of-two counter: 7 -> 0 up, 0 -> 7 down.
    load_b = 1'b1; d_b = 3'd7;
    tick();
    check("b_ld7", int'(q_b), 7);
    load_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
    #1;
    check("b_tc7", int'(tc_b), 1);
    tick();
    check("b_up_q", int'(q_b), 0);
    check("b_up_w", int'(wrap_b), 1);
    tick();
    check("b_q1", int'(q_b), 1);
    check("b_w1", int'(wrap_b), 0);
    up_b = 1'b0;
    tick();
    check("b_q0", int'(q_b), 0);
    tick();
    check("b_dn_q", int'(q_b), 7);
    check("b_dn_w", int'(wrap_b), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
